// File: rtl/arp_cache_pkg.sv
// arp_cache_pkg
// Shared constants for the ARP cache lookup block.
// - Layout of a table entry word: IP in [31:0], MAC in [79:32], valid at bit 80.
// - IP and MAC field widths.
// - clog2 helper, used to size the table address and the encoder index.
package arp_cache_pkg;

    localparam int IP_WIDTH      = 32;
    localparam int MAC_WIDTH     = 48;
    localparam int ENT_IP_LSB    = 0;
    localparam int ENT_MAC_LSB   = 32;
    localparam int ENT_VALID_BIT = 80;

    // Ceiling log2. An input of 1 returns 0.
    function automatic int clog2(input int value);
        int v;
        int r;
        v = value - 1;
        r = 0;
        for (int k = 0; k < 32; k++) begin
            if (v > 0) begin
                r = r + 1;
                v = v >> 1;
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/arp_prio_enc.sv
// arp_prio_enc
// Combinational priority encoder. When several bits are set, the lowest
// index wins.
// Ports:
//   i_vec  in  WIDTH      request vector
//   o_any  out 1          at least one bit of i_vec is set
//   o_idx  out IDX_WIDTH  lowest set index; 0 when o_any is 0
module arp_prio_enc
    import arp_cache_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int IDX_WIDTH = clog2(WIDTH)
) (
    input  logic [WIDTH-1:0]     i_vec,
    output logic                 o_any,
    output logic [IDX_WIDTH-1:0] o_idx
);

    // Scan from the top down so that the last hit, which is the lowest index, is kept.
    always_comb begin
        o_any = 1'b0;
        o_idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_any = 1'b1;
                o_idx = i[IDX_WIDTH-1:0];
            end else begin
                o_idx = o_idx;
            end
        end
    end

endmodule

// File: rtl/arp_cache_lookup.sv
// arp_cache_lookup
// Cache that maps a next-hop IP to a MAC address. Entries are written by
// the host through the register table port. Lookups run through a
// two-stage pipeline with back-pressure on the response side.
// Ports:
//   AXI_ACLK / AXI_RESETN          clock; asynchronous active-low reset
//   tbl_rd_* / tbl_wr_*            register table access; each request gets a one-cycle ack
//   lkp_req_valid/ready, lkp_nh_ip, lkp_oq
//                                  lookup request channel
//   lkp_rsp_valid/ready, lkp_rsp_hit, lkp_rsp_mac, lkp_rsp_oq
//                                  lookup response channel
//   cnt_clear, hit_count, miss_count
//                                  statistics counters; cnt_clear zeroes both
module arp_cache_lookup
    import arp_cache_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int TBL_DEPTH          = 32,
    parameter int TBL_ADDR_WIDTH     = clog2(TBL_DEPTH),
    parameter int OQ_WIDTH           = 8
) (
    input  logic                            AXI_ACLK,
    input  logic                            AXI_RESETN,
    input  logic                            tbl_rd_req,
    input  logic [TBL_ADDR_WIDTH-1:0]       tbl_rd_addr,
    output logic [3*C_S_AXI_DATA_WIDTH-1:0] tbl_rd_data,
    output logic                            tbl_rd_ack,
    input  logic                            tbl_wr_req,
    input  logic [TBL_ADDR_WIDTH-1:0]       tbl_wr_addr,
    input  logic [3*C_S_AXI_DATA_WIDTH-1:0] tbl_wr_data,
    output logic                            tbl_wr_ack,
    input  logic                            lkp_req_valid,
    output logic                            lkp_req_ready,
    input  logic [IP_WIDTH-1:0]             lkp_nh_ip,
    input  logic [OQ_WIDTH-1:0]             lkp_oq,
    output logic                            lkp_rsp_valid,
    input  logic                            lkp_rsp_ready,
    output logic                            lkp_rsp_hit,
    output logic [MAC_WIDTH-1:0]            lkp_rsp_mac,
    output logic [OQ_WIDTH-1:0]             lkp_rsp_oq,
    input  logic                            cnt_clear,
    output logic [31:0]                     hit_count,
    output logic [31:0]                     miss_count
);

    localparam int ENT_WIDTH = 3 * C_S_AXI_DATA_WIDTH;

    logic [IP_WIDTH-1:0]       r_ip  [TBL_DEPTH];
    logic [MAC_WIDTH-1:0]      r_mac [TBL_DEPTH];
    logic [TBL_DEPTH-1:0]      r_vld;

    logic [ENT_WIDTH-1:0]      r_rd_data;
    logic                      r_rd_ack;
    logic                      r_wr_ack;
    logic [ENT_WIDTH-1:0]      w_rd_word;
    logic                      w_unused_wr;

    logic [TBL_DEPTH-1:0]      w_match;
    logic                      w_stall;
    logic                      r_s1_valid;
    logic [TBL_DEPTH-1:0]      r_s1_match;
    logic [OQ_WIDTH-1:0]       r_s1_oq;
    logic                      w_any;
    logic [TBL_ADDR_WIDTH-1:0] w_idx;

    logic                      r_rsp_valid;
    logic                      r_rsp_hit;
    logic [MAC_WIDTH-1:0]      r_rsp_mac;
    logic [OQ_WIDTH-1:0]       r_rsp_oq;
    logic [31:0]               r_hit_cnt;
    logic [31:0]               r_miss_cnt;

    // The reserved upper bits of a written entry are not stored.
    assign w_unused_wr = ^tbl_wr_data[ENT_WIDTH-1:ENT_VALID_BIT+1];

    // Table storage. Host writes land on the edge after the request.
    always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
        if (!AXI_RESETN) begin
            for (int i = 0; i < TBL_DEPTH; i++) begin
                r_ip[i]  <= '0;
                r_mac[i] <= '0;
            end
            r_vld    <= '0;
            r_wr_ack <= 1'b0;
        end else begin
            r_wr_ack <= tbl_wr_req;
            if (tbl_wr_req) begin
                r_ip[tbl_wr_addr]  <= tbl_wr_data[ENT_IP_LSB +: IP_WIDTH];
                r_mac[tbl_wr_addr] <= tbl_wr_data[ENT_MAC_LSB +: MAC_WIDTH];
                r_vld[tbl_wr_addr] <= tbl_wr_data[ENT_VALID_BIT];
            end
        end
    end

    // Build the read-back word. Reserved bits read as zero.
    always_comb begin
        w_rd_word                            = '0;
        w_rd_word[ENT_IP_LSB +: IP_WIDTH]    = r_ip[tbl_rd_addr];
        w_rd_word[ENT_MAC_LSB +: MAC_WIDTH]  = r_mac[tbl_rd_addr];
        w_rd_word[ENT_VALID_BIT]             = r_vld[tbl_rd_addr];
    end

    // Register the read port. The read samples the table before a write on
    // the same edge lands, so a read and write to one address in the same
    // cycle returns the old contents.
    always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
        if (!AXI_RESETN) begin
            r_rd_data <= '0;
            r_rd_ack  <= 1'b0;
        end else begin
            r_rd_ack <= tbl_rd_req;
            if (tbl_rd_req) begin
                r_rd_data <= w_rd_word;
            end
        end
    end

    // Compare the request IP against every entry. An entry must be valid to
    // match, so an invalid entry holding IP 0 never hits.
    always_comb begin
        w_match = '0;
        for (int i = 0; i < TBL_DEPTH; i++) begin
            w_match[i] = r_vld[i] && (r_ip[i] == lkp_nh_ip);
        end
    end

    assign w_stall       = r_rsp_valid && !lkp_rsp_ready;
    assign lkp_req_ready = !w_stall;

    // Stage 1: capture the match vector and oq. This stage holds while the
    // response channel is stalled.
    always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
        if (!AXI_RESETN) begin
            r_s1_valid <= 1'b0;
            r_s1_match <= '0;
            r_s1_oq    <= '0;
        end else if (!w_stall) begin
            r_s1_valid <= lkp_req_valid;
            r_s1_match <= w_match;
            r_s1_oq    <= lkp_oq;
        end
    end

    arp_prio_enc #(
        .WIDTH     (TBL_DEPTH),
        .IDX_WIDTH (TBL_ADDR_WIDTH)
    ) u_prio_enc (
        .i_vec (r_s1_match),
        .o_any (w_any),
        .o_idx (w_idx)
    );

    // Stage 2: load the response registers. A bubble in stage 1 clears
    // valid but leaves the payload unchanged.
    always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
        if (!AXI_RESETN) begin
            r_rsp_valid <= 1'b0;
            r_rsp_hit   <= 1'b0;
            r_rsp_mac   <= '0;
            r_rsp_oq    <= '0;
        end else if (!w_stall) begin
            r_rsp_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_rsp_hit <= w_any;
                r_rsp_mac <= w_any ? r_mac[w_idx] : {MAC_WIDTH{1'b0}};
                r_rsp_oq  <= r_s1_oq;
            end
        end
    end

    // Count each lookup once, when its response is loaded. A clear in the
    // same cycle takes priority and the increment is dropped.
    always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
        if (!AXI_RESETN) begin
            r_hit_cnt  <= 32'd0;
            r_miss_cnt <= 32'd0;
        end else if (cnt_clear) begin
            r_hit_cnt  <= 32'd0;
            r_miss_cnt <= 32'd0;
        end else if (!w_stall && r_s1_valid) begin
            if (w_any) begin
                r_hit_cnt <= r_hit_cnt + 32'd1;
            end else begin
                r_miss_cnt <= r_miss_cnt + 32'd1;
            end
        end
    end

    assign tbl_rd_data   = r_rd_data;
    assign tbl_rd_ack    = r_rd_ack;
    assign tbl_wr_ack    = r_wr_ack;
    assign lkp_rsp_valid = r_rsp_valid;
    assign lkp_rsp_hit   = r_rsp_hit;
    assign lkp_rsp_mac   = r_rsp_mac;
    assign lkp_rsp_oq    = r_rsp_oq;
    assign hit_count     = r_hit_cnt;
    assign miss_count    = r_miss_cnt;

endmodule
